fft_sequencer: RTL
==================

# fft_sequencer

Control block for the in-place radix-2 decimation-in-time FFT over the N-entry complex register file. It sequences one full transform in three phases:
- **LOAD:** accepts N samples into bit-reversed addresses.
- **COMPUTE:** issues every butterfly pair and twiddle index, stage by stage, and tracks the butterfly pipeline writeback.
- **UNLOAD:** streams results in natural order under valid/ready.

It owns no sample data. It only drives addresses, enables and handshakes to the register file and the butterfly datapath.

## Interface
- N, 64, transform length (power of 2, ≥4)
- LOG2N, 6, log2(N)
- BF_LAT, 2, butterfly datapath latency in cycles from issue to writeback (≥1)

- clk  in  1  clock; all state updates on the falling edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a transform; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a transform completes
- in_valid  in  1  input sample present
- in_ready  out  1  high throughout LOAD
- load_we  out  1  in_valid & in_ready
- load_addr  out  LOG2N  bit-reverse of the load count
- bf_valid  out  1  butterfly issue strobe
- bf_idx_a  out  LOG2N  upper-leg read index
- bf_idx_b  out  LOG2N  lower-leg read index
- bf_tw  out  LOG2N-1  twiddle index
- wb_valid  out  1  bf_valid delayed BF_LAT cycles
- wb_idx_a  out  LOG2N  bf_idx_a delayed BF_LAT cycles
- wb_idx_b  out  LOG2N  bf_idx_b delayed BF_LAT cycles
- out_valid  out  1  high throughout UNLOAD
- out_ready  in  1  downstream accepts
- rd_addr  out  LOG2N  natural-order read index (combinational read of the register file)

## Operation
- **States:** IDLE, LOAD, ISSUE, GAP, UNLOAD, DONE.
- **IDLE:**
  - start=1 → LOAD, with load count cleared.
  - start in any other state is ignored.
- **LOAD:**
  - Each in_valid&in_ready cycle writes load_addr = bitrev(cnt), then increments cnt.
  - in_valid=0 stalls; load_addr holds.
  - The handshake at cnt=N-1 → ISSUE, with s=0 and k=0.
- **ISSUE (stage s, butterfly k in 0..N/2-1):**
  - half = 1<<s, grp = k>>s, pos = k & (half-1).
  - bf_idx_a = grp·2·half + pos; bf_idx_b = bf_idx_a + half; bf_tw = pos << (LOG2N-1-s).
  - bf_valid=1 every ISSUE cycle; k increments each cycle.
  - k=N/2-1 → GAP.
- **GAP:**
  - bf_valid=0 for exactly BF_LAT cycles, so the last writeback of stage s lands before stage s+1 reads.
  - Then: if s<LOG2N-1, s++ and → ISSUE; otherwise → UNLOAD with rd_addr=0.
- **Writeback:** wb_valid, wb_idx_a and wb_idx_b are a BF_LAT-deep shift register of the issue signals. The delay pipeline is never stalled.
- **UNLOAD:**
  - Each out_valid&out_ready cycle increments rd_addr.
  - out_ready=0 holds rd_addr.
  - The handshake at rd_addr=N-1 → DONE.
- **DONE:** done=1 and busy=1 for one cycle, then → IDLE. start in DONE is ignored.
- **Arithmetic:** all counters are unsigned and wrap modulo their width. No counter may wrap within a phase.

## Timing
- **Reset:** asserting rst forces IDLE immediately. All outputs go to 0, all counters clear and the wb pipeline flushes. This applies in every state, including mid-COMPUTE. A new start is required after release.
- **Start latency:** start sampled on edge t → in_ready=1 from t.
- **COMPUTE duration:** LOG2N·(N/2 + BF_LAT) cycles from the first bf_valid through the end of the last GAP. This is 204 cycles at the defaults.
- **Last writeback:** the last wb_valid occurs in the final GAP cycle. UNLOAD starts the next cycle with out_valid=1 and rd_addr=0.
- **Minimum transform:** with ready/valid always high, start to done is N + LOG2N·(N/2+BF_LAT) + N + 1 cycles.
- **Handshakes:** in_ready and out_valid are registered state decodes and never depend combinationally on in_valid or out_ready.

## Test plan
- **Reset:** rst low at arbitrary inputs → every output 0 and busy=0. Release with start=0 → the block stays in IDLE.
- **Load order:** start, then in_valid held high → load_addr = 0, 32, 16, 48, 8, 40, … and load_we=1 for exactly 64 cycles. in_ready falls after the 64th sample. Repeat with in_valid low on every third cycle → same address sequence, with addresses held during the gaps.
- **Issue pattern:**
  - Stage 0 → (0,1,tw0), (2,3,0), …, (62,63,0).
  - Stage 1 → (0,2,0), (1,3,16), (4,6,0), …
  - Stage 5 → (0,32,0), (1,33,1), …, (31,63,31).
  - Exactly 2 bf_valid=0 cycles between stages; 204 cycles total.
- **Writeback:** wb_idx_a/wb_idx_b equal bf_idx_a/bf_idx_b from 2 cycles earlier. No wb_valid occurs once UNLOAD begins.
- **Unload backpressure:** out_ready random at 50% → rd_addr visits 0..63 exactly once, in order, held while stalled. done pulses once, the cycle after the 64th handshake, then busy=0.
- **Abuse:**
  - start pulsed in LOAD, ISSUE and DONE → no effect on any sequence.
  - rst low in stage 3 → outputs 0 immediately. A subsequent start runs a complete, correct transform.

Source files
------------

// File: rtl/fft_sequencer_if.sv
// Handshake and addressing bundle between the FFT sequencer and its register file,
// butterfly datapath and the load/unload streams.
interface fft_sequencer_if #(
  parameter int LOG2N = 6
);
  logic             start;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic             load_we;
  logic [LOG2N-1:0] load_addr;
  logic             bf_valid;
  logic [LOG2N-1:0] bf_idx_a;
  logic [LOG2N-1:0] bf_idx_b;
  logic [LOG2N-2:0] bf_tw;
  logic             wb_valid;
  logic [LOG2N-1:0] wb_idx_a;
  logic [LOG2N-1:0] wb_idx_b;
  logic             out_valid;
  logic             out_ready;
  logic [LOG2N-1:0] rd_addr;

  modport master (
    input  start, in_valid, out_ready,
    output busy, done, in_ready, load_we, load_addr,
           bf_valid, bf_idx_a, bf_idx_b, bf_tw,
           wb_valid, wb_idx_a, wb_idx_b,
           out_valid, rd_addr
  );

  modport slave (
    output start, in_valid, out_ready,
    input  busy, done, in_ready, load_we, load_addr,
           bf_valid, bf_idx_a, bf_idx_b, bf_tw,
           wb_valid, wb_idx_a, wb_idx_b,
           out_valid, rd_addr
  );
endinterface

// File: rtl/fft_sequencer.sv
// Sequencer for an in-place radix-2 DIT FFT: bit-reversed load, stage-by-stage
// butterfly issue with writeback tracking, and natural-order unload.
module fft_sequencer #(
  parameter int N      = 64,
  parameter int LOG2N  = 6,
  parameter int BF_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  fft_sequencer_if.master bus
);

  localparam int KW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int GW = $clog2(BF_LAT + 1);

  localparam logic [LOG2N-1:0] LAST_N = LOG2N'(N - 1);
  localparam logic [KW-1:0]    LAST_K = KW'(N / 2 - 1);
  localparam logic [SW-1:0]    LAST_S = SW'(LOG2N - 1);
  localparam logic [GW-1:0]    LAST_G = GW'(BF_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_GAP,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [LOG2N-1:0] rd_q, rd_d;

  logic             wb_vld_q [BF_LAT];
  logic             wb_vld_d [BF_LAT];
  logic [LOG2N-1:0] wb_a_q   [BF_LAT];
  logic [LOG2N-1:0] wb_a_d   [BF_LAT];
  logic [LOG2N-1:0] wb_b_q   [BF_LAT];
  logic [LOG2N-1:0] wb_b_d   [BF_LAT];

  logic             issue;
  logic [KW-1:0]    mask_k;
  logic [KW-1:0]    pos_k;
  logic [KW-1:0]    hi_k;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] idx_a;
  logic [LOG2N-1:0] idx_b;
  logic [SW-1:0]    tw_sh;
  logic [KW-1:0]    tw;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  // Next-state and counter updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    k_d     = k_q;
    gap_d   = gap_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_N) begin
            state_d = S_ISSUE;
            cnt_d   = '0;
            s_d     = '0;
            k_d     = '0;
          end
        end
      end
      S_ISSUE: begin
        k_d = k_q + 1'b1;
        if (k_q == LAST_K) begin
          state_d = S_GAP;
          k_d     = '0;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == LAST_G) begin
          gap_d = '0;
          if (s_q == LAST_S) begin
            state_d = S_UNLOAD;
            s_d     = '0;
            rd_d    = '0;
          end else begin
            state_d = S_ISSUE;
            s_d     = s_q + 1'b1;
          end
        end
      end
      S_UNLOAD: begin
        if (bus.out_ready) begin
          rd_d = rd_q + 1'b1;
          if (rd_q == LAST_N) begin
            state_d = S_DONE;
            rd_d    = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Butterfly index generation: idx_a is k with a zero inserted at bit s
  always_comb begin
    issue  = (state_q == S_ISSUE);
    mask_k = ~({KW{1'b1}} << s_q);
    pos_k  = k_q & mask_k;
    hi_k   = k_q & ~mask_k;
    half   = LOG2N'(1) << s_q;
    idx_a  = {hi_k, 1'b0} | {1'b0, pos_k};
    idx_b  = idx_a | half;
    tw_sh  = SW'(LOG2N - 1) - s_q;
    tw     = pos_k << tw_sh;
  end

  // Writeback delay line, never stalled
  always_comb begin
    wb_vld_d[0] = issue;
    wb_a_d[0]   = issue ? idx_a : '0;
    wb_b_d[0]   = issue ? idx_b : '0;
    for (int i = 1; i < BF_LAT; i++) begin
      wb_vld_d[i] = wb_vld_q[i-1];
      wb_a_d[i]   = wb_a_q[i-1];
      wb_b_d[i]   = wb_b_q[i-1];
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      k_q     <= '0;
      gap_q   <= '0;
      rd_q    <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        wb_vld_q[i] <= 1'b0;
        wb_a_q[i]   <= '0;
        wb_b_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      rd_q    <= rd_d;
      for (int i = 0; i < BF_LAT; i++) begin
        wb_vld_q[i] <= wb_vld_d[i];
        wb_a_q[i]   <= wb_a_d[i];
        wb_b_q[i]   <= wb_b_d[i];
      end
    end
  end

  // Output decode: handshakes depend only on registered state
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.in_ready  = (state_q == S_LOAD);
    bus.load_we   = bus.in_valid & (state_q == S_LOAD);
    bus.load_addr = bitrev(cnt_q);
    bus.bf_valid  = issue;
    bus.bf_idx_a  = issue ? idx_a : '0;
    bus.bf_idx_b  = issue ? idx_b : '0;
    bus.bf_tw     = issue ? tw : '0;
    bus.wb_valid  = wb_vld_q[BF_LAT-1];
    bus.wb_idx_a  = wb_a_q[BF_LAT-1];
    bus.wb_idx_b  = wb_b_q[BF_LAT-1];
    bus.out_valid = (state_q == S_UNLOAD);
    bus.rd_addr   = rd_q;
  end

endmodule
